// File: rtl/mcycle_muldiv.sv
// Multi-cycle unsigned multiply/divide unit, one bit per clock.
// Busy stalls the datapath from the Start cycle until the results are loaded.
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] COMPUTING = 1'b1;
    localparam int         CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic             op_q;
    logic [WIDTH-1:0] opnd2_q;   // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] hi, lo;    // mul: product {hi,lo}; div: remainder / quotient
    logic [WIDTH-1:0] hi_next, lo_next;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             q_bit;

    assign Busy = ((state == IDLE) && Start) || (state == COMPUTING);

    // lo holds the multiplier for mul (consumed LSB first) and the dividend for
    // div (consumed MSB first); freed bits are refilled with product / quotient.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd2_q} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        q_bit     = (div_shift >= {1'b0, opnd2_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd2_q;
        if (op_q) begin
            hi_next = q_bit ? div_diff : div_shift[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], q_bit};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            count   <= '0;
            op_q    <= 1'b0;
            opnd2_q <= '0;
            hi      <= '0;
            lo      <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= COMPUTING;
                        count   <= '0;
                        op_q    <= MCycleOp;
                        opnd2_q <= Operand2;
                        hi      <= '0;
                        lo      <= Operand1;
                    end
                end
                default: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state   <= IDLE;
                        count   <= '0;
                        Result1 <= lo_next;
                        Result2 <= hi_next;
                    end
                end
            endcase
        end
    end
endmodule
